// File: rtl/pulse_stretch_tx_if.sv
// Request/level bundle for pulse_stretch_tx.
// Pi: strobe in; Lo/Busy/Pending/Overflow: registered status out.
interface pulse_stretch_tx_if #(
    parameter int MAX_PENDING = 3,
    localparam int PW = $clog2(MAX_PENDING + 1)
);
    logic          Pi;
    logic          Lo;
    logic          Busy;
    logic [PW-1:0] Pending;
    logic          Overflow;

    modport master (
        output Pi,
        input  Lo, Busy, Pending, Overflow
    );

    modport slave (
        input  Pi,
        output Lo, Busy, Pending, Overflow
    );
endinterface

// File: rtl/pulse_stretch_tx.sv
// Stretches one-clock strobes into HOLD-high / GAP-low level pulses.
// Ports: Clk, ResetN (async low), bus.{Pi in; Lo, Busy, Pending, Overflow out}.
module pulse_stretch_tx #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int MAX_PENDING = 3
) (
    input  logic                 Clk,
    input  logic                 ResetN,
    pulse_stretch_tx_if.slave    bus
);
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam int MX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    // Keep the counter at least one bit wide when both lengths are 1.
    localparam int CW = (MX > 1) ? $clog2(MX) : 1;

    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] P_MAX   = PW'(MAX_PENDING);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] pending;
    logic          lo;
    logic          busy;
    logic          overflow;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state    <= S_IDLE;
            cnt      <= '0;
            pending  <= '0;
            lo       <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.Pi) begin
                        state <= S_HIGH;
                        cnt   <= HOLD_LD;
                        lo    <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (cnt == '0) begin
                        state <= S_GAP;
                        cnt   <= GAP_LD;
                        lo    <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                    if (bus.Pi) begin
                        if (pending == P_MAX) overflow <= 1'b1;
                        else                  pending  <= pending + PW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                        if (bus.Pi) begin
                            if (pending == P_MAX) overflow <= 1'b1;
                            else                  pending  <= pending + PW'(1);
                        end
                    end else if (pending != '0) begin
                        // Dequeue; a strobe this cycle refills the slot.
                        state <= S_HIGH;
                        cnt   <= HOLD_LD;
                        lo    <= 1'b1;
                        if (!bus.Pi) pending <= pending - PW'(1);
                    end else if (bus.Pi) begin
                        // Empty queue: the strobe starts the pulse directly.
                        state <= S_HIGH;
                        cnt   <= HOLD_LD;
                        lo    <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    pending <= '0;
                    lo      <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Lo       = lo;
    assign bus.Busy     = busy;
    assign bus.Pending  = pending;
    assign bus.Overflow = overflow;
endmodule
